// File: rtl/ale_job_loader.sv
// Byte-stream job loader: assembles a 68-byte little-endian header into the miner's job
// registers, pulses the update trigger and streams the payload as packed 32-bit writes.
module ale_job_loader #(
  parameter int unsigned NONCE_BYTE_LEN  = 24,
  parameter int unsigned MAX_CHUNK_BYTES = 286,
  parameter int unsigned HDR_BYTES       = 68
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            S_Valid_I,
  output logic            S_Ready_O,
  input  logic [7:0]      S_Data_I,
  input  logic            S_Last_I,
  output logic            UpdateTrigger_O,
  output logic [31:0]     GroupDirections_O,
  output logic [31:0]     Groups_O,
  output logic [31:0]     ChunkLength_O,
  output logic [7:0][31:0] Target_O,
  output logic [5:0][31:0] Nonce_O,
  output logic            Wr_O,
  output logic [31:0]     Data_O,
  output logic            Done_O,
  output logic            Err_O,
  output logic            Busy_O
);

  typedef enum logic [2:0] {StIdle, StHdr, StTrig, StPay, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [6:0]                idx_q, idx_d;
  logic [HDR_BYTES-1:0][7:0] hdr_q, hdr_d;
  logic [8:0]                pay_len_q, pay_len_d;
  logic [8:0]                cnt_q, cnt_d;
  logic [31:0]               acc_q, acc_d;
  logic                      last67_q, last67_d;
  logic [31:0]               gd_q, gd_d, grp_q, grp_d, len_q, len_d, data_q, data_d;
  logic [7:0][31:0]          tgt_q, tgt_d;
  logic [5:0][31:0]          nonce_q, nonce_d;
  logic                      trig_q, trig_d, wr_q, wr_d, done_q, done_d, err_q, err_d;

  logic        accept;
  logic [31:0] hdr_len;
  logic [31:0] word;
  logic        final_byte;

  assign S_Ready_O = (state_q != StTrig);
  assign accept    = S_Valid_I && S_Ready_O;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hdr_d     = hdr_q;
    pay_len_d = pay_len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    last67_d  = last67_q;
    gd_d      = gd_q;
    grp_d     = grp_q;
    len_d     = len_q;
    tgt_d     = tgt_q;
    nonce_d   = nonce_q;
    data_d    = data_q;
    trig_d    = 1'b0;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    hdr_len   = '0;
    word      = '0;
    final_byte = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          hdr_d[0] = S_Data_I;
          if (S_Last_I) begin
            err_d = 1'b1;
          end else begin
            idx_d   = 7'd1;
            state_d = StHdr;
          end
        end
      end

      StHdr: begin
        if (accept) begin
          hdr_d[idx_q] = S_Data_I;
          hdr_len      = hdr_d[11:8];
          if (idx_q == 7'(HDR_BYTES - 1)) begin
            if (hdr_len < NONCE_BYTE_LEN || hdr_len > MAX_CHUNK_BYTES) begin
              err_d   = 1'b1;
              state_d = S_Last_I ? StIdle : StDrain;
            end else if (S_Last_I && hdr_len != NONCE_BYTE_LEN) begin
              // Frame ended before any payload although one was announced.
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              gd_d      = hdr_d[3:0];
              grp_d     = hdr_d[7:4];
              len_d     = hdr_len;
              tgt_d     = hdr_d[43:12];
              nonce_d   = hdr_d[67:44];
              trig_d    = 1'b1;
              pay_len_d = 9'(hdr_len - NONCE_BYTE_LEN);
              last67_d  = S_Last_I;
              state_d   = StTrig;
            end
          end else if (S_Last_I) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end

      StTrig: begin
        cnt_d = '0;
        acc_d = '0;
        if (pay_len_q == 9'd0) begin
          if (last67_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StDrain;
          end
        end else begin
          state_d = StPay;
        end
      end

      StPay: begin
        if (accept) begin
          word = (cnt_q[1:0] == 2'd0) ? 32'd0 : acc_q;
          word[{cnt_q[1:0], 3'b000} +: 8] = S_Data_I;
          final_byte = (cnt_q == 9'(pay_len_q - 9'd1));
          acc_d = word;
          cnt_d = cnt_q + 9'd1;
          if (cnt_q[1:0] == 2'd3 || final_byte || S_Last_I) begin
            wr_d   = 1'b1;
            data_d = word;
          end
          if (final_byte) begin
            done_d  = S_Last_I;
            err_d   = !S_Last_I;
            state_d = S_Last_I ? StIdle : StDrain;
          end else if (S_Last_I) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end

      StDrain: begin
        if (accept && S_Last_I) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      hdr_q     <= '0;
      pay_len_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      last67_q  <= 1'b0;
      gd_q      <= '0;
      grp_q     <= '0;
      len_q     <= '0;
      tgt_q     <= '0;
      nonce_q   <= '0;
      data_q    <= '0;
      trig_q    <= 1'b0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hdr_q     <= hdr_d;
      pay_len_q <= pay_len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      last67_q  <= last67_d;
      gd_q      <= gd_d;
      grp_q     <= grp_d;
      len_q     <= len_d;
      tgt_q     <= tgt_d;
      nonce_q   <= nonce_d;
      data_q    <= data_d;
      trig_q    <= trig_d;
      wr_q      <= wr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign UpdateTrigger_O   = trig_q;
  assign GroupDirections_O = gd_q;
  assign Groups_O          = grp_q;
  assign ChunkLength_O     = len_q;
  assign Target_O          = tgt_q;
  assign Nonce_O           = nonce_q;
  assign Wr_O              = wr_q;
  assign Data_O            = data_q;
  assign Done_O            = done_q;
  assign Err_O             = err_q;
  assign Busy_O            = (state_q != StIdle);

endmodule

// File: tb/tb_ale_job_loader.sv
// Bench for ale_job_loader: directed and random frames checked against a frame-level model.
module tb_ale_job_loader;

  logic             Clk, Rst_n;
  logic             S_Valid_I, S_Ready_O, S_Last_I;
  logic [7:0]       S_Data_I;
  logic             UpdateTrigger_O, Wr_O, Done_O, Err_O, Busy_O;
  logic [31:0]      GroupDirections_O, Groups_O, ChunkLength_O, Data_O;
  logic [7:0][31:0] Target_O;
  logic [5:0][31:0] Nonce_O;

  ale_job_loader dut (
    .Clk               (Clk),
    .Rst_n             (Rst_n),
    .S_Valid_I         (S_Valid_I),
    .S_Ready_O         (S_Ready_O),
    .S_Data_I          (S_Data_I),
    .S_Last_I          (S_Last_I),
    .UpdateTrigger_O   (UpdateTrigger_O),
    .GroupDirections_O (GroupDirections_O),
    .Groups_O          (Groups_O),
    .ChunkLength_O     (ChunkLength_O),
    .Target_O          (Target_O),
    .Nonce_O           (Nonce_O),
    .Wr_O              (Wr_O),
    .Data_O            (Data_O),
    .Done_O            (Done_O),
    .Err_O             (Err_O),
    .Busy_O            (Busy_O)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: everything the DUT emits for one frame.
  bit          mon_clr = 0;
  int          cyc = 0;
  logic [31:0] got_wr[$];
  int          got_trig, got_done, got_err, trig_cyc, done_cyc, first_wr_cyc;
  bit          done_with_wr;
  logic [31:0] cap_len;
  logic [255:0] cap_tgt;

  always @(negedge Clk) begin
    cyc++;
    if (mon_clr) begin
      got_wr.delete();
      got_trig = 0; got_done = 0; got_err = 0;
      trig_cyc = -1; done_cyc = -1; first_wr_cyc = -1;
      done_with_wr = 0;
    end else begin
      if (Wr_O) begin
        got_wr.push_back(Data_O);
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
      end
      if (UpdateTrigger_O) begin
        got_trig++;
        trig_cyc = cyc;
        cap_len  = ChunkLength_O;
        cap_tgt  = Target_O;
      end
      if (Done_O) begin
        got_done++;
        done_cyc = cyc;
        if (Wr_O) done_with_wr = 1;
      end
      if (Err_O) got_err++;
    end
  end

  // Frame under construction and model expectations.
  logic [7:0]   fb[$];
  bit           fl[$];
  logic [31:0]  exp_wr[$];
  bit           exp_trig, exp_done, exp_err;
  int           exp_p;
  logic [31:0]  exp_gd = 0, exp_grp = 0, exp_len = 0;
  logic [255:0] exp_tgt = 0;
  logic [191:0] exp_nonce = 0;
  bit           gaps = 0;
  int           fnum = 0;

  task automatic build_frame(input logic [31:0] len, input int npay, input int extra,
                             input int start, input int step);
    logic [31:0] gd, grp;
    fb.delete(); fl.delete();
    gd = $urandom; grp = $urandom;
    for (int i = 0; i < 4; i++) fb.push_back(8'(gd >> (8 * i)));
    for (int i = 0; i < 4; i++) fb.push_back(8'(grp >> (8 * i)));
    for (int i = 0; i < 4; i++) fb.push_back(8'(len >> (8 * i)));
    for (int i = 0; i < 56; i++) fb.push_back(8'($urandom));
    for (int j = 0; j < npay; j++) fb.push_back(start < 0 ? 8'($urandom) : 8'(start + j * step));
    for (int j = 0; j < extra; j++) fb.push_back(8'($urandom));
    for (int i = 0; i < fb.size(); i++) fl.push_back(i == fb.size() - 1);
  endtask

  task automatic take_fields();
    exp_trig = 1;
    exp_gd = 0; exp_grp = 0; exp_len = 0; exp_tgt = 0; exp_nonce = 0;
    for (int i = 0; i < 4; i++) begin
      exp_gd  = exp_gd  | (32'(fb[i])     << (8 * i));
      exp_grp = exp_grp | (32'(fb[4 + i]) << (8 * i));
      exp_len = exp_len | (32'(fb[8 + i]) << (8 * i));
    end
    for (int i = 0; i < 32; i++) exp_tgt   = exp_tgt   | (256'(fb[12 + i]) << (8 * i));
    for (int i = 0; i < 24; i++) exp_nonce = exp_nonce | (192'(fb[44 + i]) << (8 * i));
  endtask

  // Whole-frame outcome from the frame rules: where the first last flag falls decides it.
  task automatic model_frame();
    int fidx, jl, consumed;
    logic [31:0] len, w;
    exp_wr.delete(); exp_trig = 0; exp_done = 0; exp_err = 0; exp_p = 0;
    fidx = 0;
    while (fidx < fb.size() - 1 && !fl[fidx]) fidx++;
    if (fidx < 67) begin exp_err = 1; return; end
    len = {fb[11], fb[10], fb[9], fb[8]};
    if (len < 24 || len > 286) begin exp_err = 1; return; end
    exp_p = int'(len) - 24;
    if (fidx == 67) begin
      if (exp_p == 0) begin take_fields(); exp_done = 1; end
      else exp_err = 1;
      return;
    end
    take_fields();
    if (exp_p == 0) begin exp_err = 1; return; end
    jl = fidx - 68;
    consumed = (jl < exp_p) ? jl + 1 : exp_p;
    if (jl == exp_p - 1) exp_done = 1; else exp_err = 1;
    for (int k = 0; k < (consumed + 3) / 4; k++) begin
      w = 0;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < consumed) w = w | (32'(fb[68 + 4 * k + b]) << (8 * b));
      exp_wr.push_back(w);
    end
  endtask

  task automatic clear_mon();
    @(posedge Clk) mon_clr = 1;
    @(posedge Clk) mon_clr = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    bit r;
    int budget;
    if (gaps && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge Clk) S_Valid_I = 0;
      end
    end
    @(negedge Clk);
    S_Valid_I = 1; S_Data_I = d; S_Last_I = last;
    budget = 0;
    forever begin
      r = S_Ready_O;
      @(posedge Clk);
      if (r) break;
      @(negedge Clk);
      budget++;
      if (budget > 50) begin
        check_eq("ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) send_byte(fb[i], fl[i]);
    @(negedge Clk) S_Valid_I = 0; S_Last_I = 0;
  endtask

  task automatic compare_fields(input string tg);
    check_eq({tg, "_gd"},    GroupDirections_O, exp_gd);
    check_eq({tg, "_grp"},   Groups_O, exp_grp);
    check_eq({tg, "_len"},   ChunkLength_O, exp_len);
    check_eq({tg, "_tgt"},   Target_O, exp_tgt);
    check_eq({tg, "_nonce"}, Nonce_O, exp_nonce);
  endtask

  task automatic run_frame();
    string tg;
    fnum++;
    tg = $sformatf("f%0d", fnum);
    model_frame();
    clear_mon();
    send_bytes(fb.size());
    repeat (6) @(negedge Clk);
    check_eq({tg, "_trig"},  got_trig, exp_trig);
    check_eq({tg, "_done"},  got_done, exp_done);
    check_eq({tg, "_err"},   got_err, exp_err);
    check_eq({tg, "_nwr"},   got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      check_eq($sformatf("%s_wr%0d", tg, i), i < got_wr.size() ? got_wr[i] : 'x, exp_wr[i]);
    check_eq({tg, "_busy"}, Busy_O, 0);
    compare_fields(tg);
    if (exp_trig && got_trig > 0) begin
      check_eq({tg, "_len_at_trig"}, cap_len, exp_len);
      check_eq({tg, "_tgt_at_trig"}, cap_tgt, exp_tgt);
      if (exp_wr.size() > 0) check_eq({tg, "_wr_after_trig"}, first_wr_cyc > trig_cyc, 1);
      if (exp_done && exp_p > 0) check_eq({tg, "_done_with_wr"}, done_with_wr, 1);
      if (exp_done && exp_p == 0) check_eq({tg, "_done_lat"}, done_cyc, trig_cyc + 1);
    end
  endtask

  task automatic check_reset_outputs(input string tg);
    check_eq({tg, "_ready"}, S_Ready_O, 1);
    check_eq({tg, "_busy"},  Busy_O, 0);
    check_eq({tg, "_pulses"}, {UpdateTrigger_O, Wr_O, Done_O, Err_O}, 0);
    check_eq({tg, "_data"},  Data_O, 0);
    compare_fields(tg);
  endtask

  initial begin
    int kind, p;
    logic [31:0] len;
    Rst_n = 0; S_Valid_I = 0; S_Data_I = 0; S_Last_I = 0;
    repeat (3) @(negedge Clk);
    check_reset_outputs("rst");
    Rst_n = 1;

    build_frame(32, 8, 0, 1, 1);        run_frame();
    build_frame(29, 5, 0, 'hAA, 'h11);  run_frame();
    build_frame(24, 0, 0, 0, 0);        run_frame();
    build_frame(20, 0, 4, -1, 0);       run_frame();
    build_frame(300, 0, 4, -1, 0);      run_frame();
    build_frame(40, 10, 0, -1, 0);      run_frame();
    build_frame(32, 8, 0, 1, 1);        run_frame();

    gaps = 1;
    build_frame(32, 8, 0, 1, 1);        run_frame();
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 6);
      if (kind <= 2) begin
        len = $urandom_range(25, 286);
        build_frame(len, int'(len) - 24, 0, -1, 0);
      end else if (kind == 3) begin
        len = $urandom_range(0, 1) ? 32'($urandom_range(0, 23)) : $urandom;
        if (len <= 286 && len >= 24) len = 287;
        build_frame(len, 0, 4, -1, 0);
      end else if (kind == 4) begin
        len = $urandom_range(30, 120);
        p = int'(len) - 24;
        build_frame(len, $urandom_range(1, p - 1), 0, -1, 0);
      end else if (kind == 5) begin
        len = $urandom_range(25, 60);
        build_frame(len, int'(len) - 24, 2, -1, 0);
      end else begin
        build_frame(24, 0, 0, -1, 0);
      end
      run_frame();
    end

    // Reset in the middle of a payload word.
    gaps = 0;
    build_frame(40, 16, 0, 1, 1);
    clear_mon();
    send_bytes(68 + 3);
    @(negedge Clk) Rst_n = 0;
    #1;
    exp_gd = 0; exp_grp = 0; exp_len = 0; exp_tgt = 0; exp_nonce = 0;
    check_reset_outputs("midrst");
    check_eq("midrst_trig", got_trig, 1);
    check_eq("midrst_nwr",  got_wr.size(), 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1;
    build_frame(32, 8, 0, 'h11, 1);     run_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ale_job_loader.md
Name: ale_job_loader

Overview:
- Host-side writer for the miner core's job interface.
- Accepts one byte-wide valid/ready job frame (header plus chunk payload) and assembles the header fields.
- Presents the header fields on stable register outputs and pulses the update trigger once.
- Streams the payload as packed 32-bit writes, zero-padding a partial last word; sits between the host link (UART/DMA bridge) and the miner core.

Parameters:
- NONCE_BYTE_LEN, 24, nonce bytes included in ChunkLength but not carried in the payload.
- MAX_CHUNK_BYTES, 286, largest legal ChunkLength (payload of 262 bytes, 66 words).
- HDR_BYTES, 68, header length in bytes (fixed by the field list below; not to be overridden).

Ports:
- Clk  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- S_Valid_I  in  1  input byte valid
- S_Ready_O  out  1  loader can accept a byte
- S_Data_I  in  8  input byte
- S_Last_I  in  1  final byte of frame
- UpdateTrigger_O  out  1  one-cycle pulse: new job is latched
- GroupDirections_O  out  32  job field
- Groups_O  out  32  job field
- ChunkLength_O  out  32  job field, bytes including nonce
- Target_O  out  [7:0][31:0]  difficulty target, word 0 least significant
- Nonce_O  out  [5:0][31:0]  start nonce, word 0 least significant
- Wr_O  out  1  payload word write strobe
- Data_O  out  32  payload word
- Done_O  out  1  one-cycle pulse: frame fully written
- Err_O  out  1  one-cycle pulse: frame rejected or truncated
- Busy_O  out  1  frame in progress (state != IDLE)

Behaviour:
- Handshake: a byte transfers when S_Valid_I && S_Ready_O. S_Ready_O = 1 in IDLE, HDR, PAY and DRAIN; 0 in TRIG. Valid gaps are allowed at any point.
- Frame layout: GroupDirections(4), Groups(4), ChunkLength(4), Target words 0..7 (32), Nonce words 0..5 (24), then payload of ChunkLength-NONCE_BYTE_LEN bytes.
  - Every field is little-endian: the first byte goes to bits [7:0].
- Header bytes are captured into shadow registers using a byte index counter (0..67).
- Output registers are loaded from the shadows only on the TRIG transition. Rejected frames leave all outputs unchanged.
- Output reset values: all outputs 0, except S_Ready_O, which is 1 in IDLE.
- States:
  - IDLE: the first accepted byte is header byte 0; go to HDR (index=1). A byte with S_Last_I in IDLE -> Err_O, stay IDLE.
  - HDR: accept bytes up to index 67.
    - S_Last_I on any header byte -> Err_O, go to IDLE.
    - On byte 67: if length L < NONCE_BYTE_LEN or L > MAX_CHUNK_BYTES -> Err_O, then DRAIN (if byte 67 had S_Last_I, go directly to IDLE).
    - Otherwise copy shadows to outputs and go to TRIG.
  - TRIG: UpdateTrigger_O = 1 for exactly this cycle, with all field outputs already valid.
    - If P = L-NONCE_BYTE_LEN == 0: Done_O pulses the next cycle, go to IDLE. Byte 67 must have carried S_Last_I; otherwise go to DRAIN with Err_O and no Done_O.
    - Else go to PAY.
  - PAY: pack bytes little-endian into a word accumulator.
    - On the 4th byte of a word, or on payload byte P-1, the next cycle drives Wr_O = 1 with the accumulated Data_O.
    - In a partial final word, the unfilled upper bytes are 0.
    - Wr_O is a single-cycle pulse per word. The word count is ceil(P/4).
    - The first Wr_O comes no earlier than 1 cycle after UpdateTrigger_O.
  - PAY termination:
    - Payload byte P-1 with S_Last_I -> Done_O pulses coincident with the final Wr_O, go to IDLE.
    - Payload byte P-1 without S_Last_I -> final Wr_O still issued, Err_O instead of Done_O, go to DRAIN.
    - S_Last_I before byte P-1 -> flush the pending partial word with Wr_O (zero-padded), pulse Err_O, go to IDLE. The miner never reaches end of memory in this case.
  - DRAIN: discard bytes until one with S_Last_I, then go to IDLE. No outputs change.
- ChunkLength_O, Target_O, Nonce_O, Groups_O and GroupDirections_O are held stable from TRIG until the next successful TRIG.
- Counters: header index 7 bits; payload byte count 9 bits, compared against P computed once at TRIG.
- Reset mid-frame returns to IDLE immediately.
  - Wr_O, UpdateTrigger_O, Done_O and Err_O are forced to 0 while Rst_n is low.
  - Partial words are discarded.

Test Plan:
- Valid frame, L=32, payload bytes 01..08, continuous valid -> one UpdateTrigger_O; then Wr_O with Data_O=0x04030201, then Wr_O with 0x08070605; Done_O coincident with the second write.
- L=29, payload AA BB CC DD EE -> writes 0xDDCCBBAA and 0x000000EE; Done_O once; ChunkLength_O=29 throughout.
- L=24 with S_Last_I on byte 67 -> UpdateTrigger_O, zero Wr_O, Done_O on the next cycle.
- L=20, then L=300 (each followed by 4 bytes ending in S_Last_I) -> Err_O each time; no trigger and no writes; outputs keep the previous job's values.
- L=40 with S_Last_I on payload byte 9 -> writes 0x..,0x.., then a padded 0x0000xxxx; Err_O, no Done_O; the next frame loads normally.
- Random S_Valid_I gaps, plus reset asserted after payload byte 3 -> identical write data to the gap-free case; after reset all outputs are 0 and the next frame is accepted from byte 0.
